pc_fetch_unit: RTL and testbench

- Program-counter stage directly upstream of the instruction memory in the single-cycle CPU.
- Holds the PC and drives the byte address into instruction memory.
- Computes the next PC from the controller's PCSrc select: sequential, branch, jump or register jump.
- Tracks run/halt/fault status and counts retired instructions for the test bench.

---
 rtl/cpu_defs.sv | 18 +
 rtl/next_pc_calc.sv | 39 +++
 rtl/pc_fetch_unit.sv | 90 +++++++++
 tb/tb_pc_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the fetch path of the single-cycle CPU.
// Holds the PCSrc select codes, the fetch status encodings and the word size.
package cpu_defs;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC target and legality check.
// Ports: pcsrc/iaddr/immediate/jaddr/rs_data in; target, illegal out.
module next_pc_calc
    import cpu_defs::*;
#(
    parameter int IMEM_BYTES = 64
) (
    input  logic [1:0]  pcsrc,
    input  logic [31:0] iaddr,
    input  logic [15:0] immediate,
    input  logic [25:0] jaddr,
    input  logic [31:0] rs_data,
    output logic [31:0] target,
    output logic        illegal
);

    localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - WORD_BYTES);

    logic [31:0] seq;
    logic [31:0] br_off;

    assign seq    = iaddr + 32'(WORD_BYTES);
    // Offset is in words: sign-extend, then scale to bytes.
    assign br_off = {{14{immediate[15]}}, immediate, 2'b00};

    always_comb begin
        target = seq;
        unique case (pcsrc)
            PC_SEQ:  target = seq;
            PC_BR:   target = seq + br_off;
            PC_J:    target = {seq[31:28], jaddr, 2'b00};
            PC_JR:   target = rs_data;
            default: target = seq;
        endcase
    end

    assign illegal = (target[1:0] != 2'b00) || (target > LAST_WORD);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter with run/halt/fault status and a retired-update counter.
// Ports: CLK, Reset (sync, low), PCWre, PCSrc, immediate, jaddr, rs_data,
//        halt_req in; IAddr, PC4, halted, fault, fault_addr, retired out.
module pc_fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] immediate,
    input  logic [25:0] jaddr,
    input  logic [31:0] rs_data,
    input  logic        halt_req,
    output logic [31:0] IAddr,
    output logic [31:0] PC4,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] retired
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ret_q, ret_d;
    logic [31:0] fa_q, fa_d;
    logic [31:0] target;
    logic        illegal;

    next_pc_calc #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_calc (
        .pcsrc     (PCSrc),
        .iaddr     (pc_q),
        .immediate (immediate),
        .jaddr     (jaddr),
        .rs_data   (rs_data),
        .target    (target),
        .illegal   (illegal)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            ret_q   <= '0;
            fa_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
            fa_q    <= fa_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ret_d   = ret_q;
        fa_d    = fa_q;
        case (state_q)
            ST_RUN: begin
                // Halt wins over any PC write in the same cycle.
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (PCWre) begin
                    if (illegal) begin
                        state_d = ST_FAULT;
                        fa_d    = target;
                    end else begin
                        pc_d  = target;
                        ret_d = ret_q + 32'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign IAddr      = pc_q;
    assign PC4        = pc_q + 32'(WORD_BYTES);
    assign halted     = (state_q == ST_HALT);
    assign fault      = (state_q == ST_FAULT);
    assign fault_addr = fa_q;
    assign retired    = ret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed plan plus random traffic.
// Driver pushes model expectations; monitor pops and compares each cycle.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [15:0] immediate;
    logic [25:0] jaddr;
    logic [31:0] rs_data;
    logic        halt_req;
    logic [31:0] IAddr, PC4, fault_addr, retired;
    logic        halted, fault;

    pc_fetch_unit #(
        .RESET_PC   (32'h0),
        .IMEM_BYTES (64)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .PCWre      (PCWre),
        .PCSrc      (PCSrc),
        .immediate  (immediate),
        .jaddr      (jaddr),
        .rs_data    (rs_data),
        .halt_req   (halt_req),
        .IAddr      (IAddr),
        .PC4        (PC4),
        .halted     (halted),
        .fault      (fault),
        .fault_addr (fault_addr),
        .retired    (retired)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
        logic [31:0] fa;
        logic        h;
        logic        f;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ret = 32'h0;
    logic [31:0] m_fa = 32'h0;
    logic        m_h = 1'b0;
    logic        m_f = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] t;
        int          off;
        if (!Reset) begin
            m_pc = 32'h0; m_ret = 32'h0; m_fa = 32'h0;
            m_h = 1'b0; m_f = 1'b0;
        end else if (m_h || m_f) begin
            // frozen until reset
        end else if (halt_req) begin
            m_h = 1'b1;
        end else if (PCWre) begin
            off = $signed(immediate);
            case (PCSrc)
                2'd0: t = m_pc + 32'd4;
                2'd1: t = m_pc + 32'd4 + 32'(off * 4);
                2'd2: t = ((m_pc + 32'd4) & 32'hF000_0000)
                          | (32'(jaddr) * 32'd4);
                default: t = rs_data;
            endcase
            if ((t % 4) != 0 || t > 32'd60) begin
                m_f = 1'b1;
                m_fa = t;
            end else begin
                m_pc = t;
                m_ret = m_ret + 32'd1;
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic we,
                       input logic [1:0] src, input logic [15:0] imm,
                       input logic [25:0] ja, input logic [31:0] rs,
                       input logic hr);
        exp_t e;
        @(negedge CLK);
        Reset = rst; PCWre = we; PCSrc = src; immediate = imm;
        jaddr = ja; rs_data = rs; halt_req = hr;
        model_step();
        e.pc = m_pc; e.ret = m_ret; e.fa = m_fa; e.h = m_h; e.f = m_f;
        q.push_back(e);
    endtask

    // Monitor: compare after every active edge that has an expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("IAddr", IAddr, e.pc);
                chk("PC4", PC4, e.pc + 32'd4);
                chk("retired", retired, e.ret);
                chk("fault_addr", fault_addr, e.fa);
                chk("halted", 32'(halted), 32'(e.h));
                chk("fault", 32'(fault), 32'(e.f));
            end
        end
    end

    initial begin
        Reset = 1'b0; PCWre = 1'b0; PCSrc = 2'd0; immediate = '0;
        jaddr = '0; rs_data = '0; halt_req = 1'b0;

        // Reset then sequential fetch
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 1, 0, 0, 0, 0, 0);
        // Back to 8, then branches
        cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 16'hFFFE, 0, 0, 0);
        cyc(1, 1, 1, 16'h0003, 0, 0, 0);
        // To 4, jump to 0x30, misaligned jr
        cyc(1, 1, 3, 0, 0, 32'h4, 0);
        cyc(1, 1, 2, 0, 26'h000000C, 0, 0);
        cyc(1, 1, 3, 0, 0, 32'h3E, 0);
        repeat (2) cyc(1, 1, 0, 0, 0, 0, 0);
        // Aligned but out of range; last legal word
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 3, 0, 0, 32'h3C, 0);
        cyc(1, 1, 3, 0, 0, 32'h40, 0);
        // Illegal target without PCWre does nothing
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 3, 0, 0, 32'h41, 0);
        // Halt together with PCWre
        repeat (3) cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1);
        repeat (10) cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 0, 0, 0, 0);
        // Backward branch wrapping below zero
        cyc(1, 1, 1, 16'hFFF0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic [31:0] rs;
            logic [15:0] im;
            r  = ($urandom_range(0, 15) != 0);
            rs = ($urandom_range(0, 3) == 0) ? $urandom
                 : 32'($urandom_range(0, 17) * 4);
            im = 16'($signed($urandom_range(0, 20)) - 10);
            cyc(r, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                im, 26'($urandom_range(0, 17)), rs,
                $urandom_range(0, 40) == 0);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
